// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: pulls command bytes from an 8-bit FIFO (read latency 1),
// assembles header + payload into a fixed-width record and presents it on a
// valid/ready interface. NOP and SYNC are consumed internally and over-length
// commands are discarded with a sticky error flag.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   fifo_data/fifo_empty    FIFO head byte (valid the cycle after a pull) / empty
//   fifo_pull               pop request, only asserted while fifo_empty=0
//   halt                    blocks new header pulls; the current command finishes
//   pipe_idle               downstream drained (releases SYNC)
//   cmd_valid/cmd_ready     record handshake
//   cmd_opcode/len/data     record fields; payload byte i at [8i+7:8i]
//   busy                    command in progress or byte pending
//   err_overlen/err_clr     sticky over-length flag and its clear
module cmd_dispatcher #(
  parameter int unsigned MAX_BYTES = 8,
  parameter logic [3:0]  OP_NOP    = 4'h0,
  parameter logic [3:0]  OP_SYNC   = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             fifo_data,
  input  logic                   fifo_empty,
  output logic                   fifo_pull,
  input  logic                   halt,
  input  logic                   pipe_idle,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [3:0]             cmd_opcode,
  output logic [3:0]             cmd_len,
  output logic [8*MAX_BYTES-1:0] cmd_data,
  output logic                   busy,
  output logic                   err_overlen,
  input  logic                   err_clr
);

  localparam int unsigned DATA_W = 8 * MAX_BYTES;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned IDX_W  = $clog2(MAX_BYTES);

  typedef enum logic [2:0] {
    S_HDR      = 3'd0,
    S_PAYLOAD  = 3'd1,
    S_DISCARD  = 3'd2,
    S_SYNC     = 3'd3,
    S_DISPATCH = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic [LEN_W-1:0]   req_q, req_d;
  logic [LEN_W-1:0]   cap_q, cap_d;
  logic [LEN_W-1:0]   tgt_q, tgt_d;
  logic               sync_q, sync_d;
  logic [3:0]         op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               pull_c;

  logic [3:0]         hdr_op;
  logic [LEN_W-1:0]   hdr_len;

  assign hdr_op  = fifo_data[7:4];
  assign hdr_len = fifo_data[3:0];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HDR;
      pending_q <= 1'b0;
      req_q     <= '0;
      cap_q     <= '0;
      tgt_q     <= '0;
      sync_q    <= 1'b0;
      op_q      <= '0;
      len_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      cap_q     <= cap_d;
      tgt_q     <= tgt_d;
      sync_q    <= sync_d;
      op_q      <= op_d;
      len_q     <= len_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Next-state, pull request and datapath updates
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cap_d   = cap_q;
    tgt_d   = tgt_q;
    sync_d  = sync_q;
    op_d    = op_q;
    len_d   = len_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    pull_c  = 1'b0;

    // A same-cycle over-length decode below overrides the clear
    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      S_HDR: begin
        if (pending_q) begin
          req_d  = '0;
          cap_d  = '0;
          tgt_d  = hdr_len;
          sync_d = 1'b0;
          if (hdr_op == OP_NOP) begin
            state_d = (hdr_len != '0) ? S_DISCARD : S_HDR;
          end else if (hdr_op == OP_SYNC) begin
            sync_d  = 1'b1;
            state_d = (hdr_len != '0) ? S_DISCARD : S_SYNC;
          end else if (hdr_len > LEN_W'(MAX_BYTES)) begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end else begin
            op_d   = hdr_op;
            len_d  = hdr_len;
            data_d = '0;
            if (hdr_len == '0) begin
              valid_d = 1'b1;
              state_d = S_DISPATCH;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end else begin
          pull_c = !fifo_empty && !halt;
        end
      end

      S_PAYLOAD, S_DISCARD: begin
        // Requests may run ahead of captures by one byte for back-to-back reads
        pull_c = !fifo_empty && (req_q < tgt_q);
        if (pull_c) req_d = LEN_W'(req_q + 1'b1);
        if (pending_q) begin
          cap_d = LEN_W'(cap_q + 1'b1);
          if (state_q == S_PAYLOAD)
            data_d[{cap_q[IDX_W-1:0], 3'b000} +: 8] = fifo_data;
          if (cap_d == tgt_q) begin
            if (state_q == S_PAYLOAD) begin
              valid_d = 1'b1;
              state_d = S_DISPATCH;
            end else begin
              state_d = sync_q ? S_SYNC : S_HDR;
            end
          end
        end
      end

      S_SYNC: begin
        if (pipe_idle) state_d = S_HDR;
      end

      S_DISPATCH: begin
        if (cmd_ready) begin
          valid_d = 1'b0;
          state_d = S_HDR;
        end
      end

      default: state_d = S_HDR;
    endcase

    pending_d = pull_c;
  end

  // Pull is gated by reset so nothing pops while the block is held in reset
  assign fifo_pull   = pull_c & rst_n;
  assign cmd_valid   = valid_q;
  assign cmd_opcode  = op_q;
  assign cmd_len     = len_q;
  assign cmd_data    = data_q;
  assign err_overlen = err_q;
  assign busy        = (state_q != S_HDR) || pending_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: a queue-backed FIFO with 1-cycle read latency, a
// stream-level reference model that turns each queued command into its
// expected record (or none), and directed plus randomized sequences.
module tb_cmd_dispatcher;

  localparam int unsigned MAXB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_pull;
  logic        halt;
  logic        pipe_idle;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        busy;
  logic        err_overlen;
  logic        err_clr;

  cmd_dispatcher #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pull(fifo_pull),
    .halt(halt), .pipe_idle(pipe_idle),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .err_overlen(err_overlen), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  len;
    logic [63:0] data;
  } rec_t;

  logic [7:0] fq[$];
  rec_t       exp_q[$];
  int         pulls[$];
  int         vq[$];
  bit         exp_err;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_disp = 0;
  int         cyc = 0;
  bit         gap_en = 1'b0;
  bit         gap_phase = 1'b0;
  bit         rnd_en = 1'b0;
  logic       s_pull, s_valid, s_busy, s_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = (fq.size() == 0) || (gap_en && gap_phase) ||
                 (rnd_en && ($urandom_range(0, 2) == 0));
  endtask

  // Queue one command and derive its expected outcome from the command rules
  task automatic add_cmd(input logic [3:0] op, input logic [3:0] n, input logic [63:0] pay);
    rec_t r;
    logic [7:0] b;
    fq.push_back({op, n});
    r.op = op; r.len = n; r.data = '0;
    for (int i = 0; i < int'(n); i++) begin
      if (i < int'(MAXB)) b = pay[8*i +: 8];
      else b = 8'($urandom);
      fq.push_back(b);
      if (i < int'(MAXB)) r.data[8*i +: 8] = b;
    end
    if (op != 4'h0 && op != 4'hF) begin
      if (n > 4'(MAXB)) exp_err = 1'b1;
      else exp_q.push_back(r);
    end
    upd_empty();
  endtask

  // One clock: sample/check at negedge, then advance the FIFO model after posedge
  task automatic step();
    @(negedge clk);
    cyc++;
    s_pull = fifo_pull; s_valid = cmd_valid; s_busy = busy; s_err = err_overlen;
    chk("pull_while_empty", 64'(fifo_pull & fifo_empty), 64'd0);
    chk("pull_in_dispatch", 64'(fifo_pull & cmd_valid), 64'd0);
    if (fifo_pull) pulls.push_back(cyc);
    if (cmd_valid) begin
      vq.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
      else begin
        chk("rec_opcode", 64'(cmd_opcode), 64'(exp_q[0].op));
        chk("rec_len", 64'(cmd_len), 64'(exp_q[0].len));
        chk("rec_data", cmd_data, exp_q[0].data);
        if (cmd_ready) begin
          exp_q.delete(0);
          n_disp++;
        end
      end
    end
    @(posedge clk);
    #1;
    if (s_pull && fq.size() > 0) fifo_data = fq.pop_front();
    gap_phase = ~gap_phase;
    if (rnd_en) begin
      cmd_ready = 1'($urandom_range(0, 1));
      pipe_idle = 1'($urandom_range(0, 1));
    end
    upd_empty();
  endtask

  task automatic run_idle(input int maxc, input string tag);
    int k = 0;
    bit idle = 1'b0;
    while (!idle && k < maxc) begin
      step();
      k++;
      idle = (fq.size() == 0) && !s_busy && !s_pull;
    end
    chk(tag, 64'(idle), 64'd1);
  endtask

  task automatic wait_pulls(input int p0, input int n, input string tag);
    int k = 0;
    while (pulls.size() - p0 < n && k < 60) begin step(); k++; end
    chk(tag, 64'(pulls.size() - p0 >= n), 64'd1);
  endtask

  initial begin
    int d0, p0, k;
    rst_n = 1'b0; fifo_data = '0; fifo_empty = 1'b1; halt = 1'b0;
    pipe_idle = 1'b1; cmd_ready = 1'b1; err_clr = 1'b0; exp_err = 1'b0;

    // Reset values
    #3;
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_pull", 64'(fifo_pull), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_overlen), 64'd0);
    chk("rst_fields", {52'd0, cmd_opcode, cmd_len, 4'd0}, 64'd0);
    chk("rst_data", cmd_data, 64'd0);

    // Basic 3-byte command: exact pull and valid cycles
    add_cmd(4'h2, 4'd3, 64'h0000_0000_0033_2211);
    step(); step();
    rst_n = 1'b1;
    pulls.delete(); vq.delete();
    repeat (12) step();
    chk("t1_pull_count", 64'(pulls.size()), 64'd4);
    if (pulls.size() >= 4)
      chk("t1_pull_offsets", 64'({8'(pulls[1]-pulls[0]), 8'(pulls[2]-pulls[0]), 8'(pulls[3]-pulls[0])}),
          64'h02_03_04);
    chk("t1_valid_cycles", 64'(vq.size()), 64'd1);
    if (vq.size() >= 1 && pulls.size() >= 1)
      chk("t1_valid_at", 64'(vq[0] - pulls[0]), 64'd6);
    chk("t1_dispatched", 64'(n_disp), 64'd1);

    // Zero-length command with backpressure
    cmd_ready = 1'b0;
    pulls.delete(); vq.delete();
    add_cmd(4'h5, 4'd0, 64'd0);
    k = 0;
    while (vq.size() == 0 && k < 20) begin step(); k++; end
    chk("t2_valid_seen", 64'(vq.size()), 64'd1);
    if (vq.size() >= 1 && pulls.size() >= 1)
      chk("t2_valid_at", 64'(vq[0] - pulls[0]), 64'd2);
    repeat (3) step();
    chk("t2_held", 64'(s_valid), 64'd1);
    cmd_ready = 1'b1;
    step(); step();
    chk("t2_valid_drop", 64'(s_valid), 64'd0);
    chk("t2_back_to_hdr", 64'(s_busy), 64'd0);

    // NOP with 10 bytes, then a 1-byte command
    d0 = n_disp;
    add_cmd(4'h0, 4'd10, 64'd0);
    add_cmd(4'h3, 4'd1, 64'h0000_0000_0000_00AA);
    run_idle(80, "t3_idle");
    chk("t3_one_dispatch", 64'(n_disp - d0), 64'd1);

    // Over-length: flag set, bytes dropped, clear works
    d0 = n_disp;
    add_cmd(4'h4, 4'd9, 64'd0);
    run_idle(80, "t4_idle");
    chk("t4_err_set", 64'(s_err), 64'd1);
    chk("t4_no_dispatch", 64'(n_disp - d0), 64'd0);
    err_clr = 1'b1; step(); err_clr = 1'b0; step();
    chk("t4_err_cleared", 64'(s_err), 64'd0);
    // Clear coinciding with a new over-length decode: set wins
    p0 = pulls.size();
    add_cmd(4'h4, 4'd10, 64'd0);
    wait_pulls(p0, 1, "t4_hdr_pulled");
    err_clr = 1'b1; step(); err_clr = 1'b0; step();
    chk("t4_set_beats_clr", 64'(s_err), 64'd1);
    run_idle(80, "t4b_idle");
    err_clr = 1'b1; step(); err_clr = 1'b0; step();
    exp_err = 1'b0;

    // SYNC barrier
    pipe_idle = 1'b0;
    p0 = pulls.size();
    add_cmd(4'hF, 4'd0, 64'd0);
    add_cmd(4'h1, 4'd0, 64'd0);
    wait_pulls(p0, 1, "t5_sync_pulled");
    p0 = pulls.size();
    repeat (6) step();
    chk("t5_busy", 64'(s_busy), 64'd1);
    chk("t5_no_pull", 64'(pulls.size() - p0), 64'd0);
    pipe_idle = 1'b1;
    k = 0;
    do begin step(); k++; end while (!s_pull && k < 10);
    chk("t5_resume", 64'(k == 2 || k == 3), 64'd1);
    run_idle(40, "t5_idle");

    // Gapped payload, halt mid-command
    gap_en = 1'b1;
    d0 = n_disp;
    p0 = pulls.size();
    add_cmd(4'h7, 4'd6, {$urandom, $urandom});
    add_cmd(4'h2, 4'd1, 64'h0000_0000_0000_005C);
    wait_pulls(p0, 4, "t6_mid_payload");
    halt = 1'b1;
    k = 0;
    while (n_disp == d0 && k < 60) begin step(); k++; end
    chk("t6_complete", 64'(n_disp - d0), 64'd1);
    p0 = pulls.size();
    repeat (8) step();
    chk("t6_halt_no_pull", 64'(pulls.size() - p0), 64'd0);
    chk("t6_halt_idle", 64'(s_busy), 64'd0);
    chk("t6_left_in_fifo", 64'(fq.size()), 64'd2);
    halt = 1'b0;
    run_idle(60, "t6_idle");
    chk("t6_second", 64'(n_disp - d0), 64'd2);

    // Reset in the middle of a payload
    p0 = pulls.size();
    add_cmd(4'h6, 4'd5, {$urandom, $urandom});
    wait_pulls(p0, 3, "t7_mid_payload");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_valid", 64'(cmd_valid), 64'd0);
    chk("t7_pull", 64'(fifo_pull), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_data", cmd_data, 64'd0);
    chk("t7_fields", 64'({cmd_opcode, cmd_len, err_overlen}), 64'd0);
    fq.delete(); exp_q.delete();
    gap_en = 1'b0;
    upd_empty();
    step(); step();
    rst_n = 1'b1;

    // Randomized command stream with random gaps, backpressure and pipe_idle
    exp_err = 1'b0;
    rnd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] op, n;
      op = 4'($urandom_range(0, 15));
      if (op == 4'h0 || op == 4'hF) n = 4'($urandom_range(0, MAXB));
      else n = 4'($urandom_range(0, 10));
      add_cmd(op, n, {$urandom, $urandom});
    end
    run_idle(6000, "rnd_idle");
    rnd_en = 1'b0; cmd_ready = 1'b1; pipe_idle = 1'b1;
    step();
    chk("rnd_err_flag", 64'(s_err), 64'(exp_err));
    chk("rnd_all_dispatched", 64'(exp_q.size()), 64'd0);
    chk("rnd_fifo_drained", 64'(fq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
